sa_out_arbiter: RTL

Per-output-port switch allocator for the mesh router. It arbitrates among the input ports whose route computation selected this output and locks the output to one winner for a whole wormhole packet (head → body → tail). It issues FIFO read strobes to the winner only while the downstream router has buffer credits. It sits between the input-port controllers (IDLE/RCU/SA) and the crossbar mux, and drives the mux select.

---
 rtl/sa_out_arbiter_if.sv | 31 +++
 rtl/sa_out_arbiter.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/sa_out_arbiter_if.sv
// Switch-allocator bundle for one router output: request/FIFO status from the
// input ports, read strobes, ownership and credit status back to them.
interface sa_out_arbiter_if #(
  parameter int unsigned NP = 5,
  parameter int unsigned SW = 3,
  parameter int unsigned CW = 3
) ();

  logic [NP-1:0]   req;
  logic [NP-1:0]   fifo_empty;
  logic [2*NP-1:0] head_type;
  logic            credit_in;
  logic [NP-1:0]   read;
  logic [NP-1:0]   gnt;
  logic [SW-1:0]   sel;
  logic            valid_out;
  logic            busy;
  logic [CW-1:0]   credit_cnt;
  logic            err_credit;

  modport master (
    input  req, fifo_empty, head_type, credit_in,
    output read, gnt, sel, valid_out, busy, credit_cnt, err_credit
  );

  modport slave (
    output req, fifo_empty, head_type, credit_in,
    input  read, gnt, sel, valid_out, busy, credit_cnt, err_credit
  );

endinterface

// File: rtl/sa_out_arbiter.sv
// Per-output switch allocator: round-robin grant, wormhole lock from head to
// tail, credit-gated FIFO reads and crossbar select.
module sa_out_arbiter #(
  parameter int unsigned NP      = 5,
  parameter int unsigned FW      = 40,
  parameter int unsigned CREDITS = 4,
  parameter int unsigned SW      = 3,
  parameter int unsigned CW      = 3
) (
  input  logic              clk,
  input  logic              rst,
  sa_out_arbiter_if.master  bus
);

  if (FW < 2) begin : g_fw_chk
    $error("flit must be wide enough to carry the 2-bit type field");
  end
  if ((1 << SW) < NP) begin : g_sw_chk
    $error("sel too narrow for NP ports");
  end
  if ((1 << CW) <= CREDITS) begin : g_cw_chk
    $error("credit counter too narrow for CREDITS");
  end

  typedef enum logic {
    IDLE,
    LOCKED
  } state_t;

  state_t          r_state;
  state_t          w_next_state;

  logic [SW-1:0]   r_sel;
  logic [SW-1:0]   r_ptr;
  logic [NP-1:0]   r_gnt;
  logic            r_busy;
  logic            r_valid;
  logic [CW-1:0]   r_cnt;
  logic            r_err;

  logic [SW-1:0]   w_winner;
  logic [SW-1:0]   w_ptr_next;
  logic [NP-1:0]   w_read;
  logic [1:0]      w_types [NP];
  logic [1:0]      w_owner_type;
  logic            w_grant;
  logic            w_rd;
  logic            w_tail;
  logic            w_cnt_full;

  // First requester at or after ptr, wrapping NP-1 -> 0.
  function automatic logic [SW-1:0] rr_pick(input logic [NP-1:0] req,
                                            input logic [SW-1:0] ptr);
    logic          found;
    logic [SW-1:0] idx;
    rr_pick = '0;
    found   = 1'b0;
    for (int unsigned k = 0; k < NP; k++) begin
      idx = SW'((32'(ptr) + k) % NP);
      if (!found && req[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  for (genvar g = 0; g < NP; g++) begin : g_types
    assign w_types[g] = bus.head_type[2*g +: 2];
  end

  assign w_winner     = rr_pick(bus.req, r_ptr);
  assign w_owner_type = w_types[r_sel];
  assign w_grant      = (r_state == IDLE) && (|bus.req);
  assign w_rd         = |w_read;
  assign w_tail       = w_rd && (w_owner_type == 2'b01);
  assign w_cnt_full   = (r_cnt == CW'(CREDITS));
  assign w_ptr_next   = (r_sel == SW'(NP - 1)) ? '0 : r_sel + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (|bus.req) w_next_state = LOCKED;
      LOCKED:  if (w_tail)   w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Only the owner may read, and never with the downstream buffer full.
  always_comb begin
    w_read = '0;
    if (r_state == LOCKED && !bus.fifo_empty[r_sel] && r_cnt != '0) begin
      w_read[r_sel] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sel  <= '0;
      r_gnt  <= '0;
      r_busy <= 1'b0;
      r_ptr  <= '0;
    end else if (w_grant) begin
      r_sel  <= w_winner;
      r_gnt  <= NP'(1) << w_winner;
      r_busy <= 1'b1;
    end else if (w_tail) begin
      r_sel  <= '0;
      r_gnt  <= '0;
      r_busy <= 1'b0;
      r_ptr  <= w_ptr_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= CW'(CREDITS);
      r_err   <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= w_rd;
      case ({w_rd, bus.credit_in})
        2'b10:   r_cnt <= r_cnt - 1'b1;
        2'b01: begin
          if (w_cnt_full) r_err <= 1'b1;
          else            r_cnt <= r_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.read       = w_read;
  assign bus.gnt        = r_gnt;
  assign bus.sel        = r_sel;
  assign bus.valid_out  = r_valid;
  assign bus.busy       = r_busy;
  assign bus.credit_cnt = r_cnt;
  assign bus.err_credit = r_err;

endmodule
